// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch (IF) and data (D) requesters.
// Ports: clk1/rst_n clock and async active-low reset; halt blocks new grants;
//   if_req/if_addr -> if_gnt/if_valid/if_rdata (fetch side);
//   d_req/d_we/d_addr/d_wdata -> d_gnt/d_valid/d_rdata (load/store side);
//   mem_en/mem_we/mem_addr/mem_wdata/mem_rdata drive the shared memory; busy spans grant..valid.
module mem_port_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32,
  parameter int MEM_LAT = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk1,
  input  logic          rst_n,
  input  logic          halt,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_gnt,
  output logic          if_valid,
  output logic [DW-1:0] if_rdata,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          d_gnt,
  output logic          d_valid,
  output logic [DW-1:0] d_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);
  typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [3:0] wcnt, starve;
  logic own_d, launch, pick_d, capture;
  always_comb begin
    launch = state == IDLE && (if_req || d_req) && !halt;
    // D wins ties unless IF has lost STARVE_MAX times in a row
    pick_d = d_req && !(if_req && starve == 4'(STARVE_MAX));
    capture = state == WAIT && wcnt == '0;
    state_nx = state;
    case (state)
      IDLE:    state_nx = launch ? LAUNCH : IDLE;
      LAUNCH:  state_nx = WAIT;
      WAIT:    state_nx = capture ? RESP : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      wcnt      <= '0;
      starve    <= '0;
      own_d     <= 1'b0;
      if_gnt    <= 1'b0;
      if_valid  <= 1'b0;
      if_rdata  <= '0;
      d_gnt     <= 1'b0;
      d_valid   <= 1'b0;
      d_rdata   <= '0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
    end else begin
      state    <= state_nx;
      if_gnt   <= launch && !pick_d;
      d_gnt    <= launch && pick_d;
      mem_en   <= launch;
      if_valid <= capture && !own_d;
      d_valid  <= capture && own_d;
      busy     <= state_nx != IDLE;
      wcnt     <= state == LAUNCH ? 4'(MEM_LAT - 1) : wcnt - {3'b0, wcnt != '0};
      if (launch) begin
        own_d     <= pick_d;
        mem_we    <= pick_d && d_we;
        mem_addr  <= pick_d ? d_addr : if_addr;
        mem_wdata <= pick_d ? d_wdata : '0;
        starve    <= !pick_d ? '0 : (if_req && starve != 4'(STARVE_MAX)) ? starve + 4'd1 : starve;
      end
      if (capture && !own_d) if_rdata <= mem_rdata;
      // mem_we still holds the launched access type here; stores leave d_rdata alone
      if (capture && own_d && !mem_we) d_rdata <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter with a latency-accurate memory model.
module tb_mem_port_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int ML = 2;
  localparam int SM = 4;

  logic clk1 = 1'b0, rst_n = 1'b0, halt = 1'b0;
  logic if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [AW-1:0] if_addr = '0, d_addr = '0;
  logic [DW-1:0] d_wdata = '0;
  logic if_gnt, if_valid, d_gnt, d_valid, mem_en, mem_we, busy;
  logic [DW-1:0] if_rdata, d_rdata, mem_wdata, mem_rdata;
  logic [AW-1:0] mem_addr;
  int cyc = 0, passed = 0, total = 0;

  always #5 clk1 = ~clk1;
  always @(posedge clk1) cyc <= cyc + 1;

  mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(ML), .STARVE_MAX(SM)) u_dut (
    .clk1(clk1), .rst_n(rst_n), .halt(halt),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_valid(d_valid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
  endtask

  task automatic check_zero(input string tag);
    chk(tag, {if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy}, '0);
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a == 10'h005 ? 32'h2842_0001 : a == 10'h3FF ? 32'h1234_5678 : {22'h2AB3C, a};
  endfunction

  logic [DW-1:0] mem [1024];
  bit wr [1024];
  logic [DW-1:0] pipe [16];
  always @(posedge clk1) begin
    if (mem_en && mem_we) begin
      mem[mem_addr] <= mem_wdata;
      wr[mem_addr] <= 1'b1;
    end
    pipe[0] <= mem_en ? (wr[mem_addr] ? mem[mem_addr] : init_val(mem_addr)) : 32'hBADC0DE0;
    for (int k = 1; k < 16; k++) pipe[k] <= pipe[k-1];
  end
  assign mem_rdata = pipe[ML-1];

  logic s_if, s_d, s_we, s_halt;
  logic [AW-1:0] s_ia, s_da;
  logic [DW-1:0] s_wd;
  always @(posedge clk1) begin
    s_if <= if_req; s_d <= d_req; s_we <= d_we; s_halt <= halt;
    s_ia <= if_addr; s_da <= d_addr; s_wd <= d_wdata;
  end

  typedef struct {bit d; int due; logic [DW-1:0] data;} exp_t;
  exp_t q[$];
  logic [DW-1:0] ref_mem [1024];
  bit ref_wr [1024];
  logic [DW-1:0] m_drd;
  int m_starve;

  always @(negedge clk1) begin : mon
    bit ed, due;
    logic [AW-1:0] a;
    exp_t e;
    if (!rst_n) begin
      q.delete();
      m_starve = 0;
      m_drd = '0;
    end else begin
      if (if_gnt || d_gnt) begin
        ed = s_d && !(s_if && m_starve == SM);
        a = ed ? s_da : s_ia;
        chk("no_overlap", q.size(), 0);
        chk("gnt_halted", s_halt, 0);
        chk("if_gnt", if_gnt, !ed);
        chk("d_gnt", d_gnt, ed);
        chk("mem_en", mem_en, 1);
        chk("mem_addr", mem_addr, a);
        chk("mem_we", mem_we, ed && s_we);
        chk("mem_wdata", mem_wdata, ed ? s_wd : '0);
        m_starve = !ed ? 0 : (s_if && m_starve < SM) ? m_starve + 1 : m_starve;
        e.d = ed;
        e.due = cyc + ML + 1;
        if (ed && s_we) begin
          ref_mem[a] = s_wd;
          ref_wr[a] = 1'b1;
          e.data = m_drd;
        end else begin
          e.data = ref_wr[a] ? ref_mem[a] : init_val(a);
          if (ed) m_drd = e.data;
        end
        q.push_back(e);
      end else chk("mem_en_idle", mem_en, 0);
      due = q.size() != 0 && q[0].due == cyc;
      if (due) e = q[0];
      chk("if_valid", if_valid, due && !e.d);
      chk("d_valid", d_valid, due && e.d);
      if (due) chk(e.d ? "d_rdata" : "if_rdata", e.d ? d_rdata : if_rdata, e.data);
      chk("busy", busy, q.size() != 0);
      if (due) void'(q.pop_front());
    end
  end

  for (genvar g = 0; g < 2; g++) begin : lat
    localparam int L = g ? 15 : 1;
    logic rq = 1'b0;
    logic ig, iv, dg, dv, me, mw, bz;
    logic [AW-1:0] ma;
    logic [DW-1:0] ir, dr, mwd, mr;
    logic [DW-1:0] p [16];
    bit done = 1'b0;
    mem_port_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(L), .STARVE_MAX(SM)) u_lat (
      .clk1(clk1), .rst_n(rst_n), .halt(1'b0),
      .if_req(rq), .if_addr(AW'(g + 7)), .if_gnt(ig), .if_valid(iv), .if_rdata(ir),
      .d_req(1'b0), .d_we(1'b0), .d_addr('0), .d_wdata('0),
      .d_gnt(dg), .d_valid(dv), .d_rdata(dr),
      .mem_en(me), .mem_we(mw), .mem_addr(ma), .mem_wdata(mwd),
      .mem_rdata(mr), .busy(bz)
    );
    always @(posedge clk1) begin
      p[0] <= me ? ({22'h0, ma} ^ 32'hC0DE_0000) : 32'hBADC0DE0;
      for (int k = 1; k < 16; k++) p[k] <= p[k-1];
    end
    assign mr = p[L-1];
    initial begin : run
      int t0, gc, vc, n;
      gc = -1; vc = -1; n = 0;
      wait (rst_n);
      @(negedge clk1);
      rq = 1'b1;
      t0 = cyc;
      for (int i = 0; i < 40 && vc < 0; i++) begin
        @(negedge clk1);
        if (ig) begin gc = cyc; rq = 1'b0; end
        if (bz) n++;
        if (iv) begin
          vc = cyc;
          chk("lat_rdata", ir, 32'hC0DE_0000 ^ 32'(g + 7));
        end
      end
      chk("lat_gnt", gc - t0, 1);
      chk("lat_valid", vc - t0, L + 2);
      chk("lat_busy", n, L + 2);
      done = 1'b1;
    end
  end

  task automatic wait_gnt(output int c);
    c = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk1);
      if (if_gnt || d_gnt) begin c = cyc; break; end
    end
    if (c < 0) chk("gnt_timeout", if_gnt || d_gnt, 1);
  endtask

  task automatic drain();
    int i;
    for (i = 0; i < 60; i++) begin
      @(negedge clk1);
      if (q.size() == 0 && !busy) break;
    end
    if (i == 60) chk("drain_timeout", q.size(), 0);
  endtask

  task automatic d_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    int t0, gc;
    @(negedge clk1);
    d_req = 1'b1; d_we = we; d_addr = a; d_wdata = wd;
    t0 = cyc;
    wait_gnt(gc);
    d_req = 1'b0;
    chk("d_gnt_lat", gc - t0, 1);
  endtask

  initial begin : main
    int t0, gc;
    logic [9:0] pat;
    repeat (2) @(negedge clk1);
    check_zero("reset_outputs");
    rst_n = 1'b1;
    @(negedge clk1);
    if_req = 1'b1; if_addr = 10'h005;
    t0 = cyc;
    wait_gnt(gc);
    if_req = 1'b0;
    chk("if_gnt_lat", gc - t0, 1);
    drain();
    d_access(1'b0, 10'h3FF, 32'h5555_AAAA);
    drain();
    d_access(1'b1, 10'h3FF, 32'hDEAD_BEEF);
    drain();
    d_access(1'b0, 10'h3FF, 32'h0);
    drain();
    d_access(1'b0, 10'h010, 32'h0);
    @(negedge clk1);
    halt = 1'b1; if_req = 1'b1; if_addr = 10'h020;
    repeat (8) begin
      @(negedge clk1);
      chk("halt_no_if_gnt", if_gnt, 0);
    end
    halt = 1'b0;
    t0 = cyc;
    wait_gnt(gc);
    if_req = 1'b0;
    chk("halt_release_lat", gc - t0, 1);
    drain();
    @(negedge clk1);
    if_req = 1'b1; if_addr = 10'h030;
    wait_gnt(gc);
    if_req = 1'b0;
    @(negedge clk1);
    #1 rst_n = 1'b0;
    #1 check_zero("async_reset");
    repeat (4) begin
      @(negedge clk1);
      check_zero("reset_hold");
    end
    rst_n = 1'b1; if_req = 1'b1; if_addr = 10'h040;
    t0 = cyc;
    wait_gnt(gc);
    if_req = 1'b0;
    chk("post_reset_gnt_lat", gc - t0, 1);
    drain();
    @(negedge clk1);
    if_req = 1'b1; d_req = 1'b1; d_we = 1'b0; if_addr = 10'h050; d_addr = 10'h060;
    pat = 10'b10000_10000;
    for (int i = 0; i < 10; i++) begin
      wait_gnt(gc);
      chk("grant_order", if_gnt, pat[i]);
    end
    if_req = 1'b0; d_req = 1'b0;
    drain();
    for (int i = 0; i < 100 && !(lat[0].done && lat[1].done); i++) @(negedge clk1);
    chk("latency_runs_done", {lat[0].done, lat[1].done}, 2'b11);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
